// File: rtl/adder_tree_pipe.sv
`default_nettype none
// adder_tree_pipe -- pipelined M-operand unsigned adder tree, one register per level,
// wrap/saturate N-bit result, valid/ready with full backpressure.   rev 1.0
module adder_tree_pipe #(
  parameter  int N = 8,
  parameter  int M = 9,
  localparam int L = $clog2(M),
  localparam int W = N + $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M*N-1:0] ops,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   res,
  output logic [W-1:0]   sum,
  output logic           ovf
);

  localparam int HALF = (M + 1) / 2;

  function automatic int lvl_cnt(input int k);
    lvl_cnt = (M + (1 << k) - 1) >> k;
  endfunction

  // Level k holds values below 2^(N+k); masking makes the unused upper bits constant.
  function automatic logic [W-1:0] lvl_mask(input int k);
    lvl_mask = '0;
    for (int b = 0; b < W; b++)
      if (b < N + k) lvl_mask[b] = 1'b1;
  endfunction

  logic                      en;
  logic [L:1]                valid_q;
  logic [L:0]                valid_at;
  logic [L-1:0]              mode_at;
  logic [L-1:0][M:0][W-1:0]  lvl;
  logic [L:1][M:0][W-1:0]    stage_d;
  logic [L:1][M:0][W-1:0]    stage_q;
  logic [W-1:0]              sum_d;
  logic                      ovf_d;
  logic [N-1:0]              res_d;
  logic [N-1:0]              res_q;
  logic                      ovf_q;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;
  assign valid_at = {valid_q, in_valid};

  always_comb begin
    lvl = '0;
    for (int j = 0; j < M; j++)
      lvl[0][j] = {{(W-N){1'b0}}, ops[j*N +: N]};
    for (int k = 1; k < L; k++)
      lvl[k] = stage_q[k];
  end

  always_comb begin
    stage_d = '0;
    for (int k = 1; k <= L; k++) begin
      for (int j = 0; j < HALF; j++) begin
        if (j < lvl_cnt(k)) begin
          // An unpaired last term is forwarded as-is (adds zero).
          if (2*j + 1 < lvl_cnt(k-1))
            stage_d[k][j] = (lvl[k-1][2*j] + lvl[k-1][2*j+1]) & lvl_mask(k);
          else
            stage_d[k][j] = lvl[k-1][2*j];
        end
      end
    end
  end

  generate
    if (L > 1) begin : g_mode_pipe
      logic [L-1:1] mode_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          mode_q <= '0;
        end else if (en) begin
          for (int k = 1; k < L; k++)
            if (valid_at[k-1]) mode_q[k] <= mode_at[k-1];
        end
      end
      assign mode_at = {mode_q, mode};
    end else begin : g_mode_direct
      assign mode_at = mode;
    end
  endgenerate

  assign sum_d = stage_d[L][0];
  assign ovf_d = |sum_d[W-1:N];
  assign res_d = (mode_at[L-1] && ovf_d) ? {N{1'b1}} : sum_d[N-1:0];

  // Data only loads behind a valid beat, so bubbles never disturb the held outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      stage_q <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      valid_q <= valid_at[L-1:0];
      for (int k = 1; k <= L; k++)
        if (valid_at[k-1]) stage_q[k] <= stage_d[k];
      if (valid_at[L-1]) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = valid_at[L];
  assign sum       = stage_q[L][0];
  assign res       = res_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_pipe.sv
`default_nettype none
// tb_adder_tree_pipe -- scoreboard bench for the default 9x8 instance and a 2x16 instance.
module tb_adder_tree_pipe;

  localparam int N9 = 8;
  localparam int M9 = 9;
  localparam int L9 = 4;
  localparam int W9 = 12;
  localparam int N2 = 16;
  localparam int M2 = 2;
  localparam int W2 = 17;

  logic clk;
  logic rst;

  logic [M9*N9-1:0] ops9;
  logic             in_valid9, in_ready9, mode9, out_valid9, out_ready9, ovf9;
  logic [N9-1:0]    res9;
  logic [W9-1:0]    sum9;

  logic [M2*N2-1:0] ops2;
  logic             in_valid2, in_ready2, mode2, out_valid2, out_ready2, ovf2;
  logic [N2-1:0]    res2;
  logic [W2-1:0]    sum2;

  adder_tree_pipe #(.N(N9), .M(M9)) dut9 (
    .clk(clk), .rst(rst), .ops(ops9), .in_valid(in_valid9), .in_ready(in_ready9),
    .mode(mode9), .out_valid(out_valid9), .out_ready(out_ready9),
    .res(res9), .sum(sum9), .ovf(ovf9)
  );

  adder_tree_pipe #(.N(N2), .M(M2)) dut2 (
    .clk(clk), .rst(rst), .ops(ops2), .in_valid(in_valid2), .in_ready(in_ready2),
    .mode(mode2), .out_valid(out_valid2), .out_ready(out_ready2),
    .res(res2), .sum(sum2), .ovf(ovf2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {ovf, res, sum}.
  logic [W9+N9:0] sb9[$];
  logic [W2+N2:0] sb2[$];
  logic [W9+N9:0] e9, held9;
  logic [W2+N2:0] e2;
  logic           stall9 = 1'b0;
  logic           idle9  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input bit cond);
    checks++;
    assert (cond) else begin
      errors++;
      $error("FAIL %s: observed 0 expected 1", tag);
    end
  endtask

  function automatic logic [W9+N9:0] model9(input logic [M9*N9-1:0] o, input logic md);
    logic [W9-1:0] s;
    logic          ov;
    logic [N9-1:0] r;
    s = '0;
    for (int i = 0; i < M9; i++) s = s + {4'b0, o[i*N9 +: N9]};
    ov = (s > 12'd255);
    r  = (md && ov) ? 8'hFF : s[N9-1:0];
    return {ov, r, s};
  endfunction

  function automatic logic [W2+N2:0] model2(input logic [M2*N2-1:0] o, input logic md);
    logic [W2-1:0] s;
    logic          ov;
    logic [N2-1:0] r;
    s  = {1'b0, o[15:0]} + {1'b0, o[31:16]};
    ov = (s > 17'h0FFFF);
    r  = (md && ov) ? 16'hFFFF : s[N2-1:0];
    return {ov, r, s};
  endfunction

  function automatic logic [M9*N9-1:0] rand72();
    logic [M9*N9-1:0] r;
    r[31:0]  = $urandom;
    r[63:32] = $urandom;
    r[71:64] = 8'($urandom);
    return r;
  endfunction

  always @(negedge clk) begin
    if (stall9) begin
      chk("hold9_valid", 64'(out_valid9), 64'd1);
      chk("hold9_data", 64'({ovf9, res9, sum9}), 64'(held9));
    end else if (idle9 && !out_valid9) begin
      chk("bubble9_data", 64'({ovf9, res9, sum9}), 64'(held9));
    end
    if (rst && out_valid9 && out_ready9) begin
      chk_true("sb9_expected_beat", sb9.size() > 0);
      if (sb9.size() > 0) begin
        e9 = sb9.pop_front();
        chk("sb9_sum", 64'(sum9), 64'(e9[W9-1:0]));
        chk("sb9_res", 64'(res9), 64'(e9[W9+N9-1:W9]));
        chk("sb9_ovf", 64'(ovf9), 64'(e9[W9+N9]));
      end
    end
    if (rst && in_valid9 && in_ready9) sb9.push_back(model9(ops9, mode9));
    stall9 = rst && out_valid9 && !out_ready9;
    idle9  = rst && !out_valid9 && !out_ready9;
    held9  = {ovf9, res9, sum9};
  end

  always @(negedge clk) begin
    if (rst && out_valid2 && out_ready2) begin
      chk_true("sb2_expected_beat", sb2.size() > 0);
      if (sb2.size() > 0) begin
        e2 = sb2.pop_front();
        chk("sb2_sum", 64'(sum2), 64'(e2[W2-1:0]));
        chk("sb2_res", 64'(res2), 64'(e2[W2+N2-1:W2]));
        chk("sb2_ovf", 64'(ovf2), 64'(e2[W2+N2]));
      end
    end
    if (rst && in_valid2 && in_ready2) sb2.push_back(model2(ops2, mode2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send9(input logic [M9*N9-1:0] o, input logic md);
    int n;
    ops9 = o;
    mode9 = md;
    in_valid9 = 1'b1;
    n = 0;
    while (!in_ready9 && n < 64) begin
      tick();
      n++;
    end
    chk_true("send9_accept_timeout", n < 64);
    tick();
  endtask

  task automatic drain9();
    int n;
    in_valid9 = 1'b0;
    out_ready9 = 1'b1;
    n = 0;
    while ((sb9.size() != 0 || out_valid9) && n < 100) begin
      tick();
      n++;
    end
    chk_true("drain9_timeout", n < 100);
  endtask

  // Single beat into an empty pipe: out_valid must rise exactly L cycles later.
  task automatic lat9(input logic [M9*N9-1:0] o, input logic md, input logic [W9+N9:0] exp);
    ops9 = o;
    mode9 = md;
    in_valid9 = 1'b1;
    chk("lat9_in_ready", 64'(in_ready9), 64'd1);
    tick();
    in_valid9 = 1'b0;
    for (int i = 0; i < L9 - 1; i++) begin
      chk("lat9_early_valid", 64'(out_valid9), 64'd0);
      tick();
    end
    chk("lat9_valid", 64'(out_valid9), 64'd1);
    chk("lat9_sum", 64'(sum9), 64'(exp[W9-1:0]));
    chk("lat9_res", 64'(res9), 64'(exp[W9+N9-1:W9]));
    chk("lat9_ovf", 64'(ovf9), 64'(exp[W9+N9]));
  endtask

  initial begin
    logic [M9*N9-1:0] seq;
    logic [W9-1:0]    hs;
    logic [N9-1:0]    hr;
    logic             ho;
    int               n;
    int               exp3[3];

    rst = 1'b1;
    ops9 = '0; in_valid9 = 1'b0; mode9 = 1'b0; out_ready9 = 1'b1;
    ops2 = '0; in_valid2 = 1'b0; mode2 = 1'b0; out_ready2 = 1'b1;
    #3 rst = 1'b0;
    tick();
    tick();

    chk("rst9_out_valid", 64'(out_valid9), 64'd0);
    chk("rst9_sum", 64'(sum9), 64'd0);
    chk("rst9_res", 64'(res9), 64'd0);
    chk("rst9_ovf", 64'(ovf9), 64'd0);
    chk("rst9_in_ready", 64'(in_ready9), 64'd1);
    chk("rst2_out_valid", 64'(out_valid2), 64'd0);
    chk("rst2_sum", 64'(sum2), 64'd0);
    chk("rst2_ovf", 64'(ovf2), 64'd0);
    rst = 1'b1;
    tick();

    lat9({M9{8'hFF}}, 1'b0, {1'b1, 8'hF7, 12'd2295});
    drain9();
    lat9({M9{8'hFF}}, 1'b1, {1'b1, 8'hFF, 12'd2295});
    drain9();
    for (int i = 0; i < M9; i++) seq[i*N9 +: N9] = 8'(i + 1);
    lat9(seq, 1'b1, {1'b0, 8'd45, 12'd45});
    drain9();

    exp3 = '{9, 18, 144};
    send9({M9{8'h01}}, 1'b0);
    send9({M9{8'h02}}, 1'b0);
    send9({M9{8'h10}}, 1'b0);
    in_valid9 = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stream_valid", 64'(out_valid9), 64'd1);
      chk("stream_sum", 64'(sum9), 64'(exp3[i]));
      chk("stream_res", 64'(res9), 64'(exp3[i]));
      chk("stream_ovf", 64'(ovf9), 64'd0);
      tick();
    end
    chk("stream_end_valid", 64'(out_valid9), 64'd0);
    drain9();

    for (int i = 0; i < 4; i++) send9(rand72(), 1'($urandom_range(0, 1)));
    in_valid9 = 1'b0;
    n = 0;
    while (!out_valid9 && n < 20) begin
      tick();
      n++;
    end
    chk_true("bp_wait_valid", n < 20);
    out_ready9 = 1'b0;
    hs = sum9; hr = res9; ho = ovf9;
    ops9 = rand72();
    mode9 = 1'($urandom_range(0, 1));
    in_valid9 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", 64'(in_ready9), 64'd0);
      chk("bp_sum", 64'(sum9), 64'(hs));
      chk("bp_res", 64'(res9), 64'(hr));
      chk("bp_ovf", 64'(ovf9), 64'(ho));
    end
    out_ready9 = 1'b1;
    tick();
    in_valid9 = 1'b0;
    drain9();

    for (int c = 0; c < 60; c++) begin
      ops9 = rand72();
      mode9 = 1'($urandom_range(0, 1));
      in_valid9 = 1'($urandom_range(0, 1));
      out_ready9 = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain9();

    send9(rand72(), 1'b0);
    send9(rand72(), 1'b1);
    in_valid9 = 1'b0;
    tick();
    tick();
    chk("rst_mid_pre_valid", 64'(out_valid9), 64'd1);
    #1 rst = 1'b0;
    sb9.delete();
    #1;
    chk("rst_mid_out_valid", 64'(out_valid9), 64'd0);
    chk("rst_mid_sum", 64'(sum9), 64'd0);
    chk("rst_mid_res", 64'(res9), 64'd0);
    chk("rst_mid_ovf", 64'(ovf9), 64'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_idle", 64'(out_valid9), 64'd0);
    end
    seq = rand72();
    lat9(seq, 1'b1, model9(seq, 1'b1));
    drain9();

    ops2 = {16'h0001, 16'hFFFF};
    mode2 = 1'b0;
    in_valid2 = 1'b1;
    chk("m2_in_ready", 64'(in_ready2), 64'd1);
    tick();
    chk("m2_wrap_valid", 64'(out_valid2), 64'd1);
    chk("m2_wrap_sum", 64'(sum2), 64'h10000);
    chk("m2_wrap_res", 64'(res2), 64'h0000);
    chk("m2_wrap_ovf", 64'(ovf2), 64'd1);
    mode2 = 1'b1;
    tick();
    chk("m2_sat_sum", 64'(sum2), 64'h10000);
    chk("m2_sat_res", 64'(res2), 64'hFFFF);
    chk("m2_sat_ovf", 64'(ovf2), 64'd1);
    ops2 = {16'h0100, 16'h1234};
    tick();
    chk("m2_small_res", 64'(res2), 64'h1334);
    chk("m2_small_ovf", 64'(ovf2), 64'd0);
    in_valid2 = 1'b0;
    tick();
    chk("m2_bubble_valid", 64'(out_valid2), 64'd0);
    n = 0;
    while (sb2.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk_true("drain2_timeout", n < 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
